// File: rtl/add_out_seq_pkg.sv
// add_out_seq_pkg: shared types and helpers for the sequential add_out responder.
// Holds the FSM state encoding and the slice-count helper.
package add_out_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        HOLD
    } add_seq_state_t;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/add_out_seq_resp_add_chunk.sv
// add_chunk: combinational CHUNK_W-bit slice adder.
// c_msb is the carry into the slice's top bit, used for signed overflow.
module add_chunk #(
    parameter int CHUNK_W = 1
) (
    input  logic [CHUNK_W-1:0] x,
    input  logic [CHUNK_W-1:0] y,
    input  logic               ci,
    output logic [CHUNK_W-1:0] s,
    output logic               co,
    output logic               c_msb
);

    // slice sum; carry into top bit recovered from top-bit sum parity
    always_comb begin
        {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK_W{1'b0}}, ci};
        c_msb   = s[CHUNK_W-1] ^ x[CHUNK_W-1] ^ y[CHUNK_W-1];
    end

endmodule

// File: rtl/add_out_seq_resp.sv
// add_out_seq_resp: sequential adder driving the add_out bus, CHUNK_W bits per clock.
// Optional signed overflow output enabled by defining ADD_OUT_SEQ_OVF_EN.
module add_out_seq_resp
    import add_out_seq_pkg::*;
#(
    parameter int add_width = 4,
    parameter int CHUNK_W   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [add_width-1:0] a,
    input  logic [add_width-1:0] b,
    input  logic                 cin,
    output logic [add_width-1:0] sum,
    output logic                 cout,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef ADD_OUT_SEQ_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int NCHUNK = chunk_count(add_width, CHUNK_W);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

    generate
        if (CHUNK_W < 1 || (add_width % CHUNK_W) != 0) begin : g_bad_chunk
            $error("add_out_seq_resp: CHUNK_W must divide add_width");
        end
    endgenerate

    add_seq_state_t state;
    add_seq_state_t nxt;

    logic [add_width-1:0] a_q;
    logic [add_width-1:0] b_q;
    logic [add_width-1:0] acc;
    logic [add_width-1:0] acc_nxt;
    logic [IDX_W-1:0]     idx;
    logic                 carry;
    logic                 last;

    logic [CHUNK_W-1:0]   sx;
    logic [CHUNK_W-1:0]   sy;
    logic [CHUNK_W-1:0]   ss;
    logic                 sco;
    logic                 scmsb;

    add_chunk #(
        .CHUNK_W(CHUNK_W)
    ) u_chunk (
        .x    (sx),
        .y    (sy),
        .ci   (carry),
        .s    (ss),
        .co   (sco),
        .c_msb(scmsb)
    );

    // select the current slice and merge its sum into the accumulator
    always_comb begin
        int off;
        off     = int'(idx) * CHUNK_W;
        sx      = a_q[off +: CHUNK_W];
        sy      = b_q[off +: CHUNK_W];
        acc_nxt = acc;
        acc_nxt[off +: CHUNK_W] = ss;
        last    = (idx == LAST);
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // next state and handshake outputs
    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nxt = CALC;
            end
            CALC: begin
                if (last) nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // operand latch, slice walk and result load on HOLD entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_nxt;
                    carry <= sco;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        sum  <= acc_nxt;
                        cout <= sco;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADD_OUT_SEQ_OVF_EN
    // signed overflow registered alongside sum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (state == CALC && last) begin
            ovf <= scmsb ^ sco;
        end
    end
`else
    logic unused_cmsb;
    assign unused_cmsb = scmsb;
`endif

endmodule

// File: tb/tb_add_out_seq_resp.sv
// tb_add_out_seq_resp: directed plus random checks of add_out_seq_resp.
// Two instances: CHUNK_W=1 (index 0) and CHUNK_W=4 (index 1).
module tb_add_out_seq_resp;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic       in_valid  [2];
    logic       in_ready  [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic       cin       [2];
    logic       cout      [2];
    logic [3:0] a         [2];
    logic [3:0] b         [2];
    logic [3:0] sum       [2];
`ifdef ADD_OUT_SEQ_OVF_EN
    logic       ovf       [2];
`endif

    int errors = 0;
    int checks = 0;

    add_out_seq_resp #(
        .add_width(4),
        .CHUNK_W  (1)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid[0]),
        .in_ready (in_ready[0]),
        .a        (a[0]),
        .b        (b[0]),
        .cin      (cin[0]),
        .sum      (sum[0]),
        .cout     (cout[0]),
        .out_valid(out_valid[0]),
        .out_ready(out_ready[0])
`ifdef ADD_OUT_SEQ_OVF_EN
        ,
        .ovf      (ovf[0])
`endif
    );

    add_out_seq_resp #(
        .add_width(4),
        .CHUNK_W  (4)
    ) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid[1]),
        .in_ready (in_ready[1]),
        .a        (a[1]),
        .b        (b[1]),
        .cin      (cin[1]),
        .sum      (sum[1]),
        .cout     (cout[1]),
        .out_valid(out_valid[1]),
        .out_ready(out_ready[1])
`ifdef ADD_OUT_SEQ_OVF_EN
        ,
        .ovf      (ovf[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full transaction on instance d, result held for 'hold' cycles
    task automatic op(input int d, input logic [3:0] aa, input logic [3:0] bb,
                      input logic cc, input int hold);
        int         n;
        int         lat;
        int         total;
        logic [3:0] es;
        logic       ec;
        logic       eo;
        total = int'(aa) + int'(bb) + int'(cc);
        es    = 4'(total % 16);
        ec    = (total >= 16);
        eo    = (aa[3] == bb[3]) && (es[3] != aa[3]);
        n = 0;
        while (!in_ready[d] && n < 20) begin
            tick();
            n++;
        end
        check("idle_ready", 32'(in_ready[d]), 32'd1);
        a[d]         = aa;
        b[d]         = bb;
        cin[d]       = cc;
        in_valid[d]  = 1'b1;
        out_ready[d] = (hold == 0);
        tick();
        a[d]   = 4'($urandom);
        b[d]   = 4'($urandom);
        cin[d] = 1'($urandom);
        in_valid[d] = 1'($urandom);
        check("busy_ready", 32'(in_ready[d]), 32'd0);
        lat = 0;
        while (!out_valid[d] && lat < 20) begin
            tick();
            lat++;
            in_valid[d] = 1'($urandom);
            a[d] = 4'($urandom);
        end
        in_valid[d] = 1'b0;
        check("latency", 32'(lat), (d == 0) ? 32'd4 : 32'd1);
        check("sum", 32'(sum[d]), 32'(es));
        check("cout", 32'(cout[d]), 32'(ec));
`ifdef ADD_OUT_SEQ_OVF_EN
        check("ovf", 32'(ovf[d]), 32'(eo));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid[d] = 1'($urandom);
            a[d] = 4'($urandom);
            b[d] = 4'($urandom);
            tick();
            check("hold_valid", 32'(out_valid[d]), 32'd1);
            check("hold_ready", 32'(in_ready[d]), 32'd0);
            check("hold_sum", 32'(sum[d]), 32'(es));
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        check("done_valid", 32'(out_valid[d]), 32'd0);
        check("done_ready", 32'(in_ready[d]), 32'd1);
        check("done_sum", 32'(sum[d]), 32'(es));
        check("done_cout", 32'(cout[d]), 32'(ec));
        if (eo) check("eo_used", 32'd1, 32'd1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            a[d]         = '0;
            b[d]         = '0;
            cin[d]       = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_sum", 32'(sum[d]), 32'd0);
            check("rst_cout", 32'(cout[d]), 32'd0);
            check("rst_valid", 32'(out_valid[d]), 32'd0);
            check("rst_ready", 32'(in_ready[d]), 32'd1);
`ifdef ADD_OUT_SEQ_OVF_EN
            check("rst_ovf", 32'(ovf[d]), 32'd0);
`endif
        end
        tick();
        tick();
        rst = 1'b1;
        tick();

        op(0, 4'h7, 4'h9, 1'b0, 0);

        a[0] = 'x;
        b[0] = 'x;
        repeat (3) tick();
        check("x_sum", 32'(sum[0]), 32'd0);
        check("x_cout", 32'(cout[0]), 32'd1);
        check("x_valid", 32'(out_valid[0]), 32'd0);

        op(0, 4'hF, 4'hF, 1'b1, 0);
        op(0, 4'h0, 4'h0, 1'b0, 0);
        op(0, 4'h3, 4'h4, 1'b0, 10);

        a[0]        = 4'h5;
        b[0]        = 4'h6;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("abort_sum", 32'(sum[0]), 32'd0);
        check("abort_cout", 32'(cout[0]), 32'd0);
        check("abort_valid", 32'(out_valid[0]), 32'd0);
        check("abort_ready", 32'(in_ready[0]), 32'd1);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_abort_valid", 32'(out_valid[0]), 32'd0);
        end
        check("post_abort_sum", 32'(sum[0]), 32'd0);

        op(0, 4'h1, 4'h1, 1'b0, 0);

        op(1, 4'h7, 4'h1, 1'b0, 0);
        op(1, 4'h8, 4'h8, 1'b0, 2);

        for (int i = 0; i < 24; i++) begin
            op(i % 2, 4'($urandom), 4'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
